// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool for one channel of a raster-ordered pixel stream.
// Optional fused ReLU on the pooled output is enabled by defining MAXPOOL_RELU_EN.
module maxpool2x2_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     frame_done
);

    localparam int HALF_W = IMG_W / 2;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic signed [DATA_W-1:0] hold_q, hold_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     frame_done_q, frame_done_d;

    // Horizontal-pair maxima of the most recent even row.
    logic signed [DATA_W-1:0] rowbuf_q [HALF_W];

    logic                     col_last;
    logic                     row_last;
    logic [IDX_W-1:0]         rb_idx;
    logic                     rb_we;
    logic signed [DATA_W-1:0] rb_rd;
    logic signed [DATA_W-1:0] hmax;
    logic signed [DATA_W-1:0] pool;
    logic signed [DATA_W-1:0] pool_act;

    assign col_last = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));
    assign rb_idx   = IDX_W'(col_q >> 1);
    assign rb_rd    = rowbuf_q[rb_idx];
    assign hmax     = (in_data > hold_q) ? in_data : hold_q;
    assign pool     = (rb_rd > hmax) ? rb_rd : hmax;

`ifdef MAXPOOL_RELU_EN
    assign pool_act = pool[DATA_W-1] ? '0 : pool;
`else
    assign pool_act = pool;
`endif

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        rb_we        = 1'b0;
        if (in_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (!col_q[0]) begin
                hold_d = in_data;
            end else if (!row_q[0]) begin
                rb_we = 1'b1;
            end else begin
                out_valid_d  = 1'b1;
                out_data_d   = pool_act;
                frame_done_d = row_last && col_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // No reset needed: every entry is rewritten on an even row before an odd row reads it.
    always_ff @(posedge clk) begin
        if (rb_we && !rst) begin
            rowbuf_q[rb_idx] <= hmax;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream on a 4x4 frame with a frame-array reference model.
// Honours MAXPOOL_RELU_EN the same way as the design.
module tb_maxpool2x2_stream;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NPIX = W * H;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 frame_done;

    int n_assert = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int n_fd     = 0;
    logic signed [DW-1:0] got[$];

    // Reference model state: the current frame as a flat array plus a raster position.
    logic signed [DW-1:0] img [NPIX];
    int                   pos = 0;
    logic signed [DW-1:0] exp_last = '0;

    maxpool2x2_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic signed [DW-1:0] max2(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DW-1:0] act(input logic signed [DW-1:0] v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 8'sd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic beat(input logic signed [DW-1:0] v, input logic vld);
        logic ev, ef;
        int r, c;
        ev = 1'b0;
        ef = 1'b0;
        @(negedge clk);
        in_valid = vld;
        in_data  = v;
        if (vld) begin
            img[pos] = v;
            r = pos / W;
            c = pos % W;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                ev = 1'b1;
                ef = (pos == NPIX - 1);
                exp_last = act(max2(max2(img[(r-1)*W + c-1], img[(r-1)*W + c]),
                                    max2(img[r*W + c-1], img[r*W + c])));
            end
            pos = (pos + 1) % NPIX;
        end
        @(posedge clk);
        #1;
        $display("beat vld=%0b in=%0d -> out_valid=%0b out_data=%0d frame_done=%0b",
                 vld, v, out_valid, out_data, frame_done);
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("frame_done", {31'd0, frame_done}, {31'd0, ef});
        chk("out_data", out_data, exp_last);
        if (out_valid === 1'b1) begin
            got.push_back(out_data);
            n_out++;
        end
        if (frame_done === 1'b1) n_fd++;
    endtask

    task automatic do_reset(input logic vld);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = vld;
        in_data  = 8'sd99;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        pos      = 0;
        exp_last = '0;
        $display("reset -> out_valid=%0b out_data=%0d frame_done=%0b", out_valid, out_data, frame_done);
        chk("rst_out_valid", {31'd0, out_valid}, 32'sd0);
        chk("rst_out_data", out_data, 32'sd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'sd0);
    endtask

    task automatic clear_counts();
        got.delete();
        n_out = 0;
        n_fd  = 0;
    endtask

    task automatic t1_frame(input int max_gap);
        for (int i = 0; i < NPIX; i++) begin
            beat(DW'(i), 1'b1);
            for (int g = 0; g < $urandom_range(max_gap, 0); g++)
                beat(DW'($urandom), 1'b0);
        end
    endtask

    initial begin
        logic signed [DW-1:0] t3 [NPIX];

        // T1: 0..15, continuous valid
        do_reset(1'b0);
        clear_counts();
        t1_frame(0);
        chk("t1_count", n_out, 4);
        chk("t1_fd_count", n_fd, 1);
        if (got.size() == 4) begin
            chk("t1_o0", got[0], 5);
            chk("t1_o1", got[1], 7);
            chk("t1_o2", got[2], 13);
            chk("t1_o3", got[3], 15);
        end

        // T2: -16..-1
        clear_counts();
        for (int i = 0; i < NPIX; i++) beat(DW'(i - 16), 1'b1);
        chk("t2_count", n_out, 4);
        if (got.size() == 4) begin
`ifdef MAXPOOL_RELU_EN
            chk("t2_o0", got[0], 0);
            chk("t2_o3", got[3], 0);
`else
            chk("t2_o0", got[0], -11);
            chk("t2_o1", got[1], -9);
            chk("t2_o2", got[2], -3);
            chk("t2_o3", got[3], -1);
`endif
        end

        // T3: extreme values in the first two windows
        clear_counts();
        for (int i = 0; i < NPIX; i++) t3[i] = DW'($urandom);
        t3[0] = -8'sd128; t3[1] = 8'sd127;  t3[2] = -8'sd128; t3[3] = -8'sd128;
        t3[4] = -8'sd128; t3[5] = -8'sd128; t3[6] = -8'sd128; t3[7] = -8'sd128;
        for (int i = 0; i < NPIX; i++) beat(t3[i], 1'b1);
        if (got.size() == 4) begin
            chk("t3_o0", got[0], 127);
`ifdef MAXPOOL_RELU_EN
            chk("t3_o1", got[1], 0);
`else
            chk("t3_o1", got[1], -128);
`endif
        end

        // T4: T1 with random gaps
        clear_counts();
        t1_frame(3);
        chk("t4_count", n_out, 4);
        chk("t4_fd_count", n_fd, 1);

        // T5: reset after 6 pixels (with a beat presented during reset), then a full frame
        for (int i = 0; i < 6; i++) beat(DW'($urandom), 1'b1);
        do_reset(1'b1);
        clear_counts();
        t1_frame(0);
        chk("t5_count", n_out, 4);
        chk("t5_fd_count", n_fd, 1);
        if (got.size() == 4) chk("t5_o3", got[3], 15);

        // T6: two frames back to back, second one random
        clear_counts();
        t1_frame(0);
        for (int i = 0; i < NPIX; i++) beat(DW'($urandom), 1'b1);
        chk("t6_count", n_out, 8);
        chk("t6_fd_count", n_fd, 2);

        // Random frames with random gaps
        for (int f = 0; f < 6; f++) begin
            clear_counts();
            for (int i = 0; i < NPIX; i++) begin
                beat(DW'($urandom), 1'b1);
                for (int g = 0; g < $urandom_range(2, 0); g++) beat(DW'($urandom), 1'b0);
            end
            chk("rand_count", n_out, 4);
            chk("rand_fd_count", n_fd, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
